// File: rtl/game_pkg.sv
// Shared types for the ball rally game logic.
// Holds the rally state encoding and player identifiers.
package game_pkg;

  typedef enum logic [2:0] {
    SERVE_WAIT,
    MOVE_A,
    MOVE_B,
    POINT,
    GAME_OVER
  } rally_state_t;

  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge pulse.
// Ports: clk_in, rst_n (sync, active-low), btn (async pin), pulse (1 cycle).
module btn_sync_edge (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic meta;
  logic sync;
  logic syncQ;

  // pulse rises three clk_in edges after the pin edge
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      syncQ <= 1'b0;
      pulse <= 1'b0;
    end else begin
      meta  <= btn;
      sync  <= meta;
      syncQ <= sync;
      pulse <= sync & ~syncQ;
    end
  end

endmodule

// File: rtl/ball_rally_fsm.sv
// Ball rally game FSM: one-hot ball, paddle hits, scores, winner.
// Ports: clk_in, rst_n, game_tick, buttons in; ball_pos, scores, state flags out.
module ball_rally_fsm
  import game_pkg::*;
#(
  parameter int NUM_POS   = 8,
  parameter int SCORE_W   = 4,
  parameter int WIN_SCORE = 9
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               game_tick,
  input  logic               serve_btn,
  input  logic               hit_btn_a,
  input  logic               hit_btn_b,
  output logic [NUM_POS-1:0] ball_pos,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               server,
  output logic               game_over,
  output logic               winner
);

  localparam int PW = $clog2(NUM_POS);
  localparam logic [PW-1:0] LAST = PW'(NUM_POS - 1);
  localparam logic [PW-1:0] FIRST = '0;
  localparam logic [PW-1:0] ONE_P = PW'(1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE_S = SCORE_W'(1);
  localparam logic [NUM_POS-1:0] LED0 = NUM_POS'(1);

  logic servePulse;
  logic hitA;
  logic hitB;
  logic tickQ;
  logic step;

  rally_state_t state;
  rally_state_t stateN;
  logic [PW-1:0] pos;
  logic [PW-1:0] posN;
  logic [SCORE_W-1:0] scoreA;
  logic [SCORE_W-1:0] scoreAN;
  logic [SCORE_W-1:0] scoreB;
  logic [SCORE_W-1:0] scoreBN;
  logic serverQ;
  logic serverN;
  logic winnerQ;
  logic winnerN;

  btn_sync_edge uServe (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .btn    (serve_btn),
    .pulse  (servePulse)
  );

  btn_sync_edge uHitA (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .btn    (hit_btn_a),
    .pulse  (hitA)
  );

  btn_sync_edge uHitB (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .btn    (hit_btn_b),
    .pulse  (hitB)
  );

  // game_tick is already in the clk_in domain
  assign step = game_tick & ~tickQ;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      tickQ   <= 1'b0;
      state   <= SERVE_WAIT;
      pos     <= FIRST;
      scoreA  <= '0;
      scoreB  <= '0;
      serverQ <= PLAYER_A;
      winnerQ <= PLAYER_A;
    end else begin
      tickQ   <= game_tick;
      state   <= stateN;
      pos     <= posN;
      scoreA  <= scoreAN;
      scoreB  <= scoreBN;
      serverQ <= serverN;
      winnerQ <= winnerN;
    end
  end

  always_comb begin
    stateN  = state;
    posN    = pos;
    scoreAN = scoreA;
    scoreBN = scoreB;
    serverN = serverQ;
    winnerN = winnerQ;
    unique case (state)
      SERVE_WAIT: begin
        posN = (serverQ == PLAYER_B) ? LAST : FIRST;
        if (servePulse) begin
          stateN = (serverQ == PLAYER_B) ? MOVE_A : MOVE_B;
        end
      end
      MOVE_B: begin
        // a return beats a coincident step: reverse, stay put
        if (hitB && pos == LAST) begin
          stateN = MOVE_A;
        end else if (step) begin
          if (pos != LAST) begin
            posN = pos + ONE_P;
          end else begin
            scoreAN = scoreA + ONE_S;
            serverN = PLAYER_B;
            stateN  = POINT;
          end
        end
      end
      MOVE_A: begin
        if (hitA && pos == FIRST) begin
          stateN = MOVE_B;
        end else if (step) begin
          if (pos != FIRST) begin
            posN = pos - ONE_P;
          end else begin
            scoreBN = scoreB + ONE_S;
            serverN = PLAYER_A;
            stateN  = POINT;
          end
        end
      end
      POINT: begin
        if (step) begin
          if (scoreA == WIN) begin
            stateN  = GAME_OVER;
            winnerN = PLAYER_A;
            posN    = FIRST;
          end else if (scoreB == WIN) begin
            stateN  = GAME_OVER;
            winnerN = PLAYER_B;
            posN    = LAST;
          end else begin
            stateN = SERVE_WAIT;
            posN   = (serverQ == PLAYER_B) ? LAST : FIRST;
          end
        end
      end
      GAME_OVER: begin
        if (servePulse) begin
          stateN  = SERVE_WAIT;
          scoreAN = '0;
          scoreBN = '0;
          serverN = PLAYER_A;
          winnerN = PLAYER_A;
          posN    = FIRST;
        end
      end
      default: begin
        stateN = SERVE_WAIT;
      end
    endcase
  end

  always_comb begin
    ball_pos = '0;
    if (state != POINT) begin
      ball_pos = LED0 << pos;
    end
  end

  assign score_a   = scoreA;
  assign score_b   = scoreB;
  assign server    = serverQ;
  assign game_over = (state == GAME_OVER);
  assign winner    = winnerQ;

endmodule

// File: tb/tb_ball_rally_fsm.sv
// Scoreboard bench for ball_rally_fsm (NUM_POS=8, WIN_SCORE=3).
// Stimulus queues cycle-tagged expectations; a negedge monitor checks them.
module tb_ball_rally_fsm;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_tick = 1'b0;
  logic       serve_btn = 1'b0;
  logic       hit_btn_a = 1'b0;
  logic       hit_btn_b = 1'b0;
  logic [7:0] ball_pos;
  logic [3:0] score_a;
  logic [3:0] score_b;
  logic       server;
  logic       game_over;
  logic       winner;

  ball_rally_fsm #(
    .NUM_POS   (8),
    .SCORE_W   (4),
    .WIN_SCORE (3)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .game_tick (game_tick),
    .serve_btn (serve_btn),
    .hit_btn_a (hit_btn_a),
    .hit_btn_b (hit_btn_b),
    .ball_pos  (ball_pos),
    .score_a   (score_a),
    .score_b   (score_b),
    .server    (server),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         at;
    logic [7:0] ball;
    logic [3:0] sa;
    logic [3:0] sb;
    logic       srv;
    logic       go;
    logic       win;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t mon;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      mon = q.pop_front();
      compared++;
      if (mon.at != cyc ||
          {ball_pos, score_a, score_b, server, game_over, winner} !==
          {mon.ball, mon.sa, mon.sb, mon.srv, mon.go, mon.win}) begin
        mismatched++;
        $display("FAIL %s @%0d(due %0d): got ball=%h a=%0d b=%0d srv=%b go=%b win=%b, want ball=%h a=%0d b=%0d srv=%b go=%b win=%b",
                 mon.nm, cyc, mon.at, ball_pos, score_a, score_b, server,
                 game_over, winner, mon.ball, mon.sa, mon.sb, mon.srv,
                 mon.go, mon.win);
      end
    end
  end

  function automatic logic [7:0] oh(input int i);
    logic [7:0] v;
    v = 8'(1) << i;
    return v;
  endfunction

  task automatic push(input int at, input logic [7:0] eb,
                      input logic [3:0] esa, input logic [3:0] esb,
                      input logic esrv, input logic ego, input logic ewin,
                      input string nm);
    exp_t e;
    e.at = at; e.ball = eb; e.sa = esa; e.sb = esb;
    e.srv = esrv; e.go = ego; e.win = ewin; e.nm = nm;
    q.push_back(e);
  endtask

  // One 10-cycle game_tick period; step lands at base+1.
  task automatic tp(input logic hA, input logic hB, input logic sv,
                    input int off, input logic [7:0] eb,
                    input logic [3:0] esa, input logic [3:0] esb,
                    input logic esrv, input logic ego, input logic ewin,
                    input int chk, input string nm);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) push(cyc + chk, eb, esa, esb, esrv, ego, ewin, nm);
      game_tick = (i < 5);
      if (i == off) begin
        hit_btn_a = hA;
        hit_btn_b = hB;
        serve_btn = sv;
      end
      if (i == off + 2) begin
        hit_btn_a = 1'b0;
        hit_btn_b = 1'b0;
        serve_btn = 1'b0;
      end
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic doReset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
    push(cyc, 8'h01, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "reset");
    rst_n = 1'b1;
  endtask

  // travel toward B, ball at index i after each step
  task automatic legB(input logic [3:0] sa, input logic [3:0] sb,
                      input logic srv, input logic endHit, input int off,
                      input string nm);
    for (int i = 1; i < 8; i++)
      tp(1'b0, endHit && i == 7, 1'b0, off, oh(i), sa, sb, srv,
         1'b0, 1'b0, 3, nm);
  endtask

  task automatic legA(input logic [3:0] sa, input logic [3:0] sb,
                      input logic srv, input logic endHit, input int off,
                      input string nm);
    for (int i = 6; i >= 0; i--)
      tp(endHit && i == 0, 1'b0, 1'b0, off, oh(i), sa, sb, srv,
         1'b0, 1'b0, 3, nm);
  endtask

  initial begin
    @(posedge clk_in);
    #1;
    doReset(3);
    tp(0, 0, 0, 0, 8'h01, 0, 0, 0, 0, 0, 3, "idle");
    tp(0, 0, 1, 0, 8'h01, 0, 0, 0, 0, 0, 3, "serveA");
    // flight with ignored hit_b at 08, serve mid-rally, hit_a at 80
    for (int i = 1; i < 8; i++)
      tp(i == 7, i == 3, i == 5, 2, oh(i), 0, 0, 0, 0, 0, 3, "flightB");
    tp(0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 3, "pointA");
    tp(0, 0, 0, 0, 8'h80, 1, 0, 1, 0, 0, 3, "parkB");
    tp(0, 0, 1, 0, 8'h80, 1, 0, 1, 0, 0, 3, "serveB");
    legA(1, 0, 1, 1'b1, 5, "returnA");
    // hit_b pin at offset 7 makes its pulse coincide with the next step
    for (int i = 1; i < 8; i++)
      tp(0, i == 7, 0, 7, oh(i), 1, 0, 1, 0, 0, 3, "flightB2");
    tp(0, 0, 0, 0, 8'h80, 1, 0, 1, 0, 0, 1, "hitOnStep");
    legA(1, 0, 1, 1'b0, 0, "flightA");
    tp(0, 0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 3, "pointB");
    tp(0, 0, 0, 0, 8'h01, 1, 1, 0, 0, 0, 3, "parkA");
    tp(0, 0, 1, 0, 8'h01, 1, 1, 0, 0, 0, 3, "serveA2");
    legB(1, 1, 0, 1'b1, 5, "toB3");
    tp(0, 0, 0, 0, 8'h40, 1, 1, 0, 0, 0, 3, "returnB");
    for (int i = 5; i >= 0; i--)
      tp(i == 0, 0, 0, 5, oh(i), 1, 1, 0, 0, 0, 3, "toA3");
    legB(1, 1, 0, 1'b0, 0, "toB4");
    tp(0, 0, 0, 0, 8'h00, 2, 1, 1, 0, 0, 3, "pointA2");
    tp(0, 0, 0, 0, 8'h80, 2, 1, 1, 0, 0, 3, "parkB2");
    tp(0, 0, 1, 0, 8'h80, 2, 1, 1, 0, 0, 3, "serveB2");
    for (int i = 6; i >= 4; i--)
      tp(0, 0, 0, 0, oh(i), 2, 1, 1, 0, 0, 3, "preRst");
    doReset(1);
    repeat (3) tp(0, 0, 0, 0, 8'h01, 0, 0, 0, 0, 0, 3, "postRst");
    // three points to A
    tp(0, 0, 1, 0, 8'h01, 0, 0, 0, 0, 0, 3, "g1serve");
    legB(0, 0, 0, 1'b0, 0, "g1B");
    tp(0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 3, "g1point");
    tp(0, 0, 0, 0, 8'h80, 1, 0, 1, 0, 0, 3, "g1park");
    for (int p = 2; p <= 3; p++) begin
      tp(0, 0, 1, 0, 8'h80, 4'(p - 1), 0, 1, 0, 0, 3, "gServe");
      legA(4'(p - 1), 0, 1, 1'b1, 5, "gA");
      legB(4'(p - 1), 0, 1, 1'b0, 0, "gB");
      tp(0, 0, 0, 0, 8'h00, 4'(p), 0, 1, 0, 0, 3, "gPoint");
      if (p == 2)
        tp(0, 0, 0, 0, 8'h80, 2, 0, 1, 0, 0, 3, "gPark");
    end
    tp(0, 0, 0, 0, 8'h01, 3, 0, 1, 1, 0, 3, "gameOver");
    tp(0, 0, 0, 0, 8'h01, 3, 0, 1, 1, 0, 3, "overHold");
    tp(0, 0, 1, 0, 8'h01, 0, 0, 0, 0, 0, 7, "restart");
    tp(0, 0, 0, 0, 8'h01, 0, 0, 0, 0, 0, 3, "restartIdle");
    repeat (5) @(posedge clk_in);
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending, want 0", q.size());
      mismatched += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
